// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared definitions for the UART receiver slice: FSM state encoding,
//   the legal oversampling ratios and the fallback ratio, plus a helper
//   that maps any requested ratio onto a legal one.
//   No ports (package).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [5:0] PRESCALE_8       = 6'd8;
  localparam logic [5:0] PRESCALE_16      = 6'd16;
  localparam logic [5:0] PRESCALE_32      = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_16;

  // Anything other than 8/16/32 would put the sample points at odd places
  // inside a bit, so unsupported ratios fall back to 16.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32)
      return p;
    return PRESCALE_DEFAULT;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Per-bit timing for the UART receiver: an edge counter that walks
//   0..prescale-1 across every bit, a payload bit counter, and the
//   three-point majority vote around the middle of each bit.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   run           counting enabled (receiver is inside a frame)
//   data_phase    receiver is shifting payload bits
//   rx            serial line after optional synchronisation
//   prescale      latched, already-legal oversampling ratio
//   sample_tick   high on the third sample point (count P/2+1)
//   bit_end       high on the last edge of a bit (count P-1)
//   last_data_bit high while the final payload bit is in progress
//   bit_val       majority of the three samples (valid with sample_tick)
module uart_rx_sampler #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       data_phase,
  input  logic       rx,
  input  logic [5:0] prescale,
  output logic       sample_tick,
  output logic       bit_end,
  output logic       last_data_bit,
  output logic       bit_val
);
  import uart_rx_pkg::*;

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [5:0]    edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          samp_lo;
  logic          samp_mid;
  logic [5:0]    half;

  assign half = prescale >> 1;

  // The edge counter idles at 0, so the cycle in which the start bit is
  // first seen already counts as edge 0 of that bit; this keeps frames
  // aligned to the line with no per-frame drift.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      samp_lo  <= 1'b0;
      samp_mid <= 1'b0;
    end else if (!run) begin
      edge_cnt <= '0;
    end else begin
      if (edge_cnt == prescale - 6'd1)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + 6'd1;
      if (edge_cnt == half - 6'd1)
        samp_lo <= rx;
      if (edge_cnt == half)
        samp_mid <= rx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (!data_phase) begin
      bit_cnt <= '0;
    end else if (bit_end) begin
      if (last_data_bit)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign sample_tick   = run && (edge_cnt == half + 6'd1);
  assign bit_end       = run && (edge_cnt == prescale - 6'd1);
  assign last_data_bit = data_phase && (bit_cnt == BW'(DATA_WIDTH - 1));

  // Third sample is the live line value, so the vote is ready on the
  // P/2+1 edge itself and the FSM can register its result there.
  assign bit_val = (samp_lo & samp_mid) | (samp_lo & rx) | (samp_mid & rx);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART receiver: start-bit detection, LSB-first payload, optional
//   even/odd parity and stop-bit check, with one-cycle result pulses.
//   Optional feature macro: UART_RX_SYNC_EN -- when defined, RX_IN passes
//   through a two-flop synchroniser (2 cycles extra latency); otherwise
//   RX_IN is assumed synchronous to clk.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   RX_IN       serial line, idles high
//   Prescale    clk cycles per bit (8, 16 or 32; others act as 16)
//   PAR_EN      parity bit follows the payload when 1
//   PAR_TYP     0 = even parity, 1 = odd parity
//   P_DATA      last good received word
//   data_valid  one-cycle pulse when P_DATA takes a new good word
//   par_err     one-cycle pulse on parity mismatch
//   stp_err     one-cycle pulse when the stop bit samples low
module uart_rx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);
  import uart_rx_pkg::*;

  state_t                state;
  logic                  rx;
  logic [5:0]            prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  start_bit_q;
  logic                  par_bit_q;
  logic                  par_bad;
  logic                  run;
  logic                  data_phase;
  logic                  sample_tick;
  logic                  bit_end;
  logic                  last_data_bit;
  logic                  bit_val;

`ifdef UART_RX_SYNC_EN
  logic sync_ff1;
  logic sync_ff2;

  // Flops reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff1 <= 1'b1;
      sync_ff2 <= 1'b1;
    end else begin
      sync_ff1 <= RX_IN;
      sync_ff2 <= sync_ff1;
    end
  end

  assign rx = sync_ff2;
`else
  assign rx = RX_IN;
`endif

  // Counting starts in the very cycle the low line is noticed in IDLE.
  assign run        = (state != ST_IDLE) || !rx;
  assign data_phase = (state == ST_DATA);
  assign par_bad    = ((^shift_reg) ^ par_typ_q) != par_bit_q;

  uart_rx_sampler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .data_phase   (data_phase),
    .rx           (rx),
    .prescale     (prescale_q),
    .sample_tick  (sample_tick),
    .bit_end      (bit_end),
    .last_data_bit(last_data_bit),
    .bit_val      (bit_val)
  );

  // Receiver FSM with registered result pulses. Configuration is captured
  // once per frame so mid-frame changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      prescale_q  <= PRESCALE_DEFAULT;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      shift_reg   <= '0;
      start_bit_q <= 1'b0;
      par_bit_q   <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx) begin
            state      <= ST_START;
            prescale_q <= legal_prescale(Prescale);
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
          end
        end
        ST_START: begin
          if (sample_tick)
            start_bit_q <= bit_val;
          // A start bit that votes high was a glitch: drop it silently.
          if (bit_end)
            state <= start_bit_q ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (sample_tick)
            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
          if (bit_end && last_data_bit)
            state <= par_en_q ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (sample_tick)
            par_bit_q <= bit_val;
          if (bit_end)
            state <= ST_STOP;
        end
        ST_STOP: begin
          // Exactly one verdict per frame; a bad stop bit outranks parity.
          if (sample_tick) begin
            if (!bit_val) begin
              stp_err <= 1'b1;
            end else if (par_en_q && par_bad) begin
              par_err <= 1'b1;
            end else begin
              data_valid <= 1'b1;
              P_DATA     <= shift_reg;
            end
          end
          // Leave on the last edge so a back-to-back start is seen next cycle.
          if (bit_end)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
  import uart_rx_pkg::*;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_compared;
  int n_mismatched;

  int cycle;
  int dv_cnt;
  int pe_cnt;
  int se_cnt;
  int dv_cycles[$];
  logic [7:0] dv_words[$];

  uart_rx_core #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      dv_cycles.push_back(cycle);
      dv_words.push_back(P_DATA);
    end
    if (par_err === 1'b1) pe_cnt = pe_cnt + 1;
    if (stp_err === 1'b1) se_cnt = se_cnt + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change 1 time unit after a rising edge.
  task automatic drive_bit(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // Config is scrambled after the start bit to show it was latched.
  task automatic send_frame(input int line_p, input logic [5:0] presc_in,
                            input logic [7:0] data, input logic par_en,
                            input logic par_typ, input logic par_bit,
                            input logic stop_bit);
    Prescale = presc_in;
    PAR_EN   = par_en;
    PAR_TYP  = par_typ;
    drive_bit(1'b0, line_p);
    Prescale = 6'd5;
    PAR_EN   = ~par_en;
    PAR_TYP  = ~par_typ;
    for (int i = 0; i < 8; i++) drive_bit(data[i], line_p);
    if (par_en) drive_bit(par_bit, line_p);
    drive_bit(stop_bit, line_p);
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_compared++;
    if (P_DATA !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_pdata: got %0h required 00", P_DATA);
    end
    n_compared++;
    if (data_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_dv: got %0b required 0", data_valid);
    end
    n_compared++;
    if (par_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_pe: got %0b required 0", par_err);
    end
    n_compared++;
    if (stp_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_se: got %0b required 0", stp_err);
    end
    n_compared++;
    if (dut.state !== ST_IDLE) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got %0d required %0d", dut.state, ST_IDLE);
    end
    idle(10);
  endtask

  task automatic test_even_parity_p8();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    send_frame(8, 6'd8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(16 + LAT);
    n_compared++;
    if (dv_cnt - dv0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL p8_dv_count: got %0d required 1", dv_cnt - dv0);
    end
    n_compared++;
    if (P_DATA !== 8'hA5) begin
      n_mismatched++;
      $display("[TB] FAIL p8_pdata: got %0h required a5", P_DATA);
    end
    n_compared++;
    if (pe_cnt - pe0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL p8_pe_count: got %0d required 0", pe_cnt - pe0);
    end
    n_compared++;
    if (se_cnt - se0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL p8_se_count: got %0d required 0", se_cnt - se0);
    end
  endtask

  task automatic test_parity_error_p16();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    send_frame(16, 6'd16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(32 + LAT);
    n_compared++;
    if (pe_cnt - pe0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL p16_pe_count: got %0d required 1", pe_cnt - pe0);
    end
    n_compared++;
    if (dv_cnt - dv0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL p16_dv_count: got %0d required 0", dv_cnt - dv0);
    end
    n_compared++;
    if (se_cnt - se0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL p16_se_count: got %0d required 0", se_cnt - se0);
    end
    n_compared++;
    if (P_DATA !== 8'hA5) begin
      n_mismatched++;
      $display("[TB] FAIL p16_pdata_hold: got %0h required a5", P_DATA);
    end
  endtask

  task automatic test_stop_error_p32();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    send_frame(32, 6'd32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(64 + LAT);
    n_compared++;
    if (se_cnt - se0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL p32_se_count: got %0d required 1", se_cnt - se0);
    end
    n_compared++;
    if (dv_cnt - dv0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL p32_dv_count: got %0d required 0", dv_cnt - dv0);
    end
    n_compared++;
    if (pe_cnt - pe0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL p32_pe_count: got %0d required 0", pe_cnt - pe0);
    end
    n_compared++;
    if (P_DATA !== 8'hA5) begin
      n_mismatched++;
      $display("[TB] FAIL p32_pdata_hold: got %0h required a5", P_DATA);
    end
  endtask

  task automatic test_glitch();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    drive_bit(1'b0, 3);
    RX_IN = 1'b1;
    repeat (12 + LAT) @(posedge clk);
    #1;
    n_compared++;
    if (dut.state !== ST_START) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_state15: got %0d required %0d", dut.state, ST_START);
    end
    @(posedge clk);
    #1;
    n_compared++;
    if (dut.state !== ST_IDLE) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_state16: got %0d required %0d", dut.state, ST_IDLE);
    end
    idle(20);
    n_compared++;
    if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_pulses: got %0d required 0",
               (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
    end
  endtask

  task automatic test_back_to_back();
    int dv0 = dv_cnt;
    send_frame(8, 6'd8, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8, 6'd8, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(16 + LAT);
    n_compared++;
    if (dv_cnt - dv0 !== 2) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_dv_count: got %0d required 2", dv_cnt - dv0);
    end
    if (dv_words.size() >= dv0 + 2) begin
      n_compared++;
      if (dv_words[dv0] !== 8'h12) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_word0: got %0h required 12", dv_words[dv0]);
      end
      n_compared++;
      if (dv_words[dv0 + 1] !== 8'h34) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_word1: got %0h required 34", dv_words[dv0 + 1]);
      end
      n_compared++;
      if (dv_cycles[dv0 + 1] - dv_cycles[dv0] !== 80) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_spacing: got %0d required 80",
                 dv_cycles[dv0 + 1] - dv_cycles[dv0]);
      end
    end else begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL b2b_words: got %0d pulses required 2", dv_words.size() - dv0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    logic [7:0] aborted = 8'h0F;
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(aborted[i], 16);
    drive_bit(aborted[4], 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    RX_IN = 1'b1;
    n_compared++;
    if (dut.state !== ST_IDLE) begin
      n_mismatched++;
      $display("[TB] FAIL abort_state: got %0d required %0d", dut.state, ST_IDLE);
    end
    idle(40);
    n_compared++;
    if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_pulses: got %0d required 0",
               (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
    end
    // Unsupported ratio 20 must behave as 16.
    send_frame(16, 6'd20, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(32 + LAT);
    n_compared++;
    if (dv_cnt - dv0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL abort_dv_count: got %0d required 1", dv_cnt - dv0);
    end
    n_compared++;
    if (P_DATA !== 8'h5A) begin
      n_mismatched++;
      $display("[TB] FAIL abort_pdata: got %0h required 5a", P_DATA);
    end
    n_compared++;
    if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_errs: got %0d required 0", (pe_cnt - pe0) + (se_cnt - se0));
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    cycle        = 0;
    dv_cnt       = 0;
    pe_cnt       = 0;
    se_cnt       = 0;
    rst          = 1'b1;
    RX_IN        = 1'b1;
    Prescale     = 6'd16;
    PAR_EN       = 1'b0;
    PAR_TYP      = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] starting uart_rx_core bench");
    test_reset();
    test_even_parity_p8();
    test_parity_error_p16();
    test_stop_error_p32();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
